// File: rtl/inert_spi_seq.sv
// Sequencer in front of the inertial-sensor SPI monarch: after power-up it issues the config writes,
// then on each sensor data-ready it issues 4 reads and publishes pitch rate / Z accel with a vld strobe.
module inert_spi_seq #(
  parameter int INIT_WAIT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);

  typedef enum logic [2:0] {
    INIT_WAIT, CFG, CFG_WAIT, IDLE, RD, RD_WAIT, PUB
  } state_t;

  state_t                    state, state_nxt;
  logic [INIT_WAIT_BITS-1:0] wait_cnt, wait_cnt_nxt;
  logic [1:0]                idx, idx_nxt;
  logic                      int_s1, int_s2, int_s3;
  logic                      int_edge;
  logic                      done_q, done_rise;
  logic                      pend, pend_nxt;
  logic                      cap;
  logic [3:0][7:0]           byt;
  logic [15:0]               cfg_word;
  logic [7:0]                rd_addr;
  logic                      unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];
  assign int_edge     = int_s2 & ~int_s3;
  assign done_rise    = done & ~done_q;

  always_comb begin
    cfg_word = 16'h0D02;
    rd_addr  = 8'hA2;
    case (idx)
      2'd0: begin cfg_word = 16'h0D02; rd_addr = 8'hA2; end
      2'd1: begin cfg_word = 16'h1053; rd_addr = 8'hA3; end
      2'd2: begin cfg_word = 16'h1150; rd_addr = 8'hAC; end
      2'd3: begin cfg_word = 16'h1460; rd_addr = 8'hAD; end
      default: ;
    endcase
  end

  // cmd is decoded from state/index so it stays stable from the wrt cycle until done_rise
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    idx_nxt      = idx;
    pend_nxt     = pend;
    cap          = 1'b0;
    wrt          = 1'b0;
    cmd          = 16'h0000;
    case (state)
      INIT_WAIT: begin
        wait_cnt_nxt = wait_cnt + 1'b1;
        if (&wait_cnt) state_nxt = CFG;
      end
      CFG: begin
        wrt       = 1'b1;
        cmd       = cfg_word;
        state_nxt = CFG_WAIT;
      end
      CFG_WAIT: begin
        cmd = cfg_word;
        if (done_rise) begin
          if (idx == 2'd3) begin
            idx_nxt   = 2'd0;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = CFG;
          end
        end
      end
      IDLE: begin
        if (int_edge || pend) begin
          idx_nxt   = 2'd0;
          pend_nxt  = 1'b0;
          state_nxt = RD;
        end
      end
      RD: begin
        wrt       = 1'b1;
        cmd       = {rd_addr, 8'h00};
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        cmd = {rd_addr, 8'h00};
        if (done_rise) begin
          cap = 1'b1;
          if (idx == 2'd3) begin
            idx_nxt   = 2'd0;
            state_nxt = PUB;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = RD;
          end
        end
      end
      PUB: state_nxt = IDLE;
      default: state_nxt = INIT_WAIT;
    endcase
    // Data-ready during a burst is remembered once; during power-up/config it is dropped
    if (int_edge && (state == RD || state == RD_WAIT || state == PUB)) pend_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_WAIT;
      wait_cnt <= '0;
      idx      <= 2'd0;
      pend     <= 1'b0;
      int_s1   <= 1'b0;
      int_s2   <= 1'b0;
      int_s3   <= 1'b0;
      done_q   <= 1'b0;
      byt      <= '0;
      ptch_rt  <= 16'h0000;
      AZ       <= 16'h0000;
      vld      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      idx      <= idx_nxt;
      pend     <= pend_nxt;
      int_s1   <= INT;
      int_s2   <= int_s1;
      int_s3   <= int_s2;
      done_q   <= done;
      if (cap) byt[idx] <= rd_data[7:0];
      vld <= (state == PUB);
      if (state == PUB) begin
        ptch_rt <= {byt[1], byt[0]};
        AZ      <= {byt[3], byt[2]};
      end
    end
  end

endmodule

// File: tb/tb_inert_spi_seq.sv
// Bench for inert_spi_seq: SPI monarch model, transaction-level reference model and directed/random INT stimulus.
module tb_inert_spi_seq;

  logic        clk, rst_n, INT, done, wrt, vld;
  logic [15:0] rd_data, cmd, ptch_rt, AZ;

  inert_spi_seq #(.INIT_WAIT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [15:0] CFG_TAB [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  localparam logic [7:0]  RD_TAB  [4] = '{8'hA2, 8'hA3, 8'hAC, 8'hAD};

  int n_tests = 0, n_fail = 0;
  logic [7:0] mem     [256];
  logic [7:0] last_rd [256];
  logic       late = 1'b0, slow = 1'b1;

  // reference model state
  int          m_txn = 0, since = 0, reads_total = 0, vld_cnt = 0;
  logic        outstanding = 1'b0, prev_done = 1'b0;
  logic [15:0] cur_cmd = 16'h0, exp_p = 16'h0, exp_a = 16'h0;
  logic [15:0] cmd_log [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction n after reset: four config writes, then reads cycling A2,A3,AC,AD
  function automatic logic [15:0] exp_cmd(input int n);
    if (n < 4) return CFG_TAB[n];
    return {RD_TAB[(n - 4) % 4], 8'h00};
  endfunction

  // SPI monarch model
  logic [15:0] s_cmd;
  int          s_lat, s_nclr;
  bit          s_abort;
  logic [7:0]  s_b;
  initial begin
    done = 1'b0; rd_data = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        #1 done = 1'b0;
      end else if (wrt) begin
        s_cmd = cmd; s_abort = 1'b0;
        #1;
        if (!late) done = 1'b0;
        s_nclr = late ? $urandom_range(1, 3) : 0;
        s_lat  = slow ? 6 : s_nclr + $urandom_range(1, 5);
        for (int k = 1; k <= s_lat; k++) begin
          @(negedge clk);
          if (!rst_n) begin s_abort = 1'b1; break; end
          #1;
          if (k == s_nclr) done = 1'b0;
        end
        if (s_abort) begin
          #1 done = 1'b0;
        end else begin
          if (s_cmd[15]) begin
            s_b = mem[s_cmd[15:8]];
            last_rd[s_cmd[15:8]] = s_b;
            rd_data = {8'($urandom), s_b};
          end else begin
            rd_data = 16'($urandom);
          end
          done = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_wrt", 32'(wrt), 0);
        chk("rst_vld", 32'(vld), 0);
        chk("rst_ptch", 32'(ptch_rt), 0);
        chk("rst_az", 32'(AZ), 0);
        m_txn = 0; since = 0; outstanding = 1'b0;
        exp_p = 16'h0; exp_a = 16'h0;
        cmd_log.delete();
      end else begin
        if (done && !prev_done) outstanding = 1'b0;
        if (wrt) begin
          chk("no_double_wrt", 32'(outstanding), 0);
          chk("cmd_seq", 32'(cmd), 32'(exp_cmd(m_txn)));
          cur_cmd = cmd; outstanding = 1'b1;
          cmd_log.push_back(cmd);
          if (cmd[15]) begin reads_total++; since++; end
          m_txn++;
        end else if (outstanding) begin
          chk("cmd_hold", 32'(cmd), 32'(cur_cmd));
        end
        if (vld) begin
          chk("vld_after_4_reads", 32'(since), 4);
          since = 0; vld_cnt++;
          exp_p = {last_rd[8'hA3], last_rd[8'hA2]};
          exp_a = {last_rd[8'hAD], last_rd[8'hAC]};
        end
        chk("ptch_rt", 32'(ptch_rt), 32'(exp_p));
        chk("AZ", 32'(AZ), 32'(exp_a));
      end
      prev_done = done;
    end
  end

  task automatic pulse_int();
    @(posedge clk); #2 INT = 1'b1;
    repeat (2) @(posedge clk);
    #2 INT = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_and_time();
    int cyc;
    cyc = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); cyc++;
      #1;
      if (wrt) break;
    end
    chk("first_wrt_cycle", 32'(cyc), 16);
  endtask

  task automatic wait_cfg_and_check();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (cmd_log.size() >= 4 && !outstanding) break;
    end
    chk("cfg_complete", 32'(cmd_log.size() >= 4), 1);
    repeat (20) @(posedge clk);
    #1;
    if (cmd_log.size() >= 4) begin
      chk("cfg0", 32'(cmd_log[0]), 32'h0D02);
      chk("cfg1", 32'(cmd_log[1]), 32'h1053);
      chk("cfg2", 32'(cmd_log[2]), 32'h1150);
      chk("cfg3", 32'(cmd_log[3]), 32'h1460);
    end
  endtask

  task automatic wait_vld(input int target);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (vld_cnt >= target) break;
    end
    chk("vld_timeout", 32'(vld_cnt >= target), 1);
  endtask

  task automatic wait_reads(input int target);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (reads_total >= target) break;
    end
    chk("read_timeout", 32'(reads_total >= target), 1);
  endtask

  int v0, r0;
  initial begin
    rst_n = 1'b0; INT = 1'b0;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); last_rd[i] = 8'h00; end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cmd", 32'(cmd), 0);

    // power-up timing, config sequence, INT ignored during config
    slow = 1'b1;
    release_and_time();
    v0 = vld_cnt; r0 = reads_total;
    pulse_int();
    pulse_int();
    wait_cfg_and_check();
    chk("no_reads_during_cfg", 32'(reads_total - r0), 0);
    chk("no_vld_during_cfg", 32'(vld_cnt - v0), 0);

    // known read data
    slow = 1'b0;
    mem[8'hA2] = 8'h34; mem[8'hA3] = 8'h12; mem[8'hAC] = 8'h78; mem[8'hAD] = 8'h56;
    v0 = vld_cnt; r0 = reads_total;
    pulse_int();
    wait_vld(v0 + 1);
    repeat (60) @(posedge clk);
    #1;
    chk("ptch_1234", 32'(ptch_rt), 32'h1234);
    chk("az_5678", 32'(AZ), 32'h5678);
    chk("one_vld", 32'(vld_cnt - v0), 1);
    chk("four_reads", 32'(reads_total - r0), 4);

    // done clears late after wrt
    late = 1'b1;
    foreach (RD_TAB[i]) mem[RD_TAB[i]] = 8'($urandom);
    v0 = vld_cnt; r0 = reads_total;
    pulse_int();
    wait_vld(v0 + 1);
    repeat (80) @(posedge clk);
    #1;
    chk("late_one_vld", 32'(vld_cnt - v0), 1);
    chk("late_four_reads", 32'(reads_total - r0), 4);
    late = 1'b0;

    // two INT pulses inside one burst merge into one extra burst
    slow = 1'b1;
    v0 = vld_cnt; r0 = reads_total;
    pulse_int();
    wait_reads(r0 + 1);
    pulse_int();
    pulse_int();
    repeat (400) @(posedge clk);
    #1;
    chk("pend_two_vld", 32'(vld_cnt - v0), 2);
    chk("pend_eight_reads", 32'(reads_total - r0), 8);

    // reset in the middle of a read
    r0 = reads_total;
    pulse_int();
    wait_reads(r0 + 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("abort_wrt", 32'(wrt), 0);
    chk("abort_vld", 32'(vld), 0);
    chk("abort_cmd", 32'(cmd), 0);
    chk("abort_ptch", 32'(ptch_rt), 0);
    chk("abort_az", 32'(AZ), 0);
    repeat (3) @(negedge clk);
    release_and_time();
    wait_cfg_and_check();
    slow = 1'b0;

    // random data-ready traffic
    v0 = vld_cnt; r0 = reads_total;
    for (int n = 0; n < 25; n++) begin
      foreach (RD_TAB[i]) mem[RD_TAB[i]] = 8'($urandom);
      late = 1'($urandom_range(0, 1));
      pulse_int();
      repeat ($urandom_range(0, 50)) @(posedge clk);
    end
    late = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("rand_reads_per_vld", 32'(reads_total - r0), 32'(4 * (vld_cnt - v0)));
    chk("rand_some_vld", 32'(vld_cnt > v0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
